// File: rtl/multi_rate_counter_pkg.sv
// Speed encoding and rate period helper shared by the multi-rate counter
// and its divider.
package rate_pkg;

    localparam int SPEED_W = 2;

    typedef enum logic [SPEED_W-1:0] {
        SPEED_CYCLE = 2'd0,
        SPEED_1X    = 2'd1,
        SPEED_2X    = 2'd2,
        SPEED_4X    = 2'd3
    } speed_e;

    // Cycles between advances for a speed code; never returns 0 so PERIOD-1 cannot underflow.
    function automatic logic [63:0] period(input logic [SPEED_W-1:0] speed,
                                           input logic [63:0]        clk_hz);
        logic [63:0] p;
        case (speed)
            SPEED_CYCLE: p = 64'd1;
            SPEED_1X:    p = clk_hz;
            SPEED_2X:    p = clk_hz << 1;
            SPEED_4X:    p = clk_hz << 2;
            default:     p = 64'd1;
        endcase
        if (p == 64'd0) begin
            p = 64'd1;
        end else begin
            p = p;
        end
        return p;
    endfunction

endpackage

// File: rtl/multi_rate_counter_if.sv
// Control/status bundle of the multi-rate counter: rate, direction and load
// controls in, registered count and event pulses out.
interface multi_rate_counter_if #(
    parameter int CNT_W = 4
);
    logic [1:0]       speed;
    logic             run;
    logic             up;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic [CNT_W-1:0] counter_value;
    logic             tick;
    logic             wrap;

    modport master (
        output speed, run, up, load, load_value,
        input  counter_value, tick, wrap
    );

    modport slave (
        input  speed, run, up, load, load_value,
        output counter_value, tick, wrap
    );
endinterface

// File: rtl/multi_rate_counter_tick_gen.sv
// Rate divider: emits a one-cycle advance strobe every PERIOD(speed) running
// cycles, restarting whenever the selected speed changes or a load occurs.
module tick_gen
    import rate_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int DIV_W  = 28
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic               restart_i,
    input  logic [SPEED_W-1:0] speed_i,
    output logic               advance_o
);

    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic [SPEED_W-1:0] speed_q;
    logic [SPEED_W-1:0] speed_d;
    logic [DIV_W-1:0]   reload_s;
    logic               advance_s;

    assign reload_s = DIV_W'(period(speed_i, 64'(CLK_HZ)) - 64'd1);

    // Divider count and the speed it was last loaded for.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q   <= '0;
            speed_q <= 2'd0;
        end else begin
            div_q   <= div_d;
            speed_q <= speed_d;
        end
    end

    // A speed change restarts the period instead of advancing on that edge.
    always_comb begin
        div_d     = div_q;
        speed_d   = speed_q;
        advance_s = 1'b0;
        if (restart_i) begin
            div_d   = reload_s;
            speed_d = speed_i;
        end else if (run_i) begin
            if (speed_i != speed_q) begin
                div_d   = reload_s;
                speed_d = speed_i;
            end else if (div_q == '0) begin
                div_d     = reload_s;
                advance_s = 1'b1;
            end else begin
                div_d = div_q - DIV_W'(1'b1);
            end
        end else begin
            div_d   = div_q;
            speed_d = speed_q;
        end
    end

    assign advance_o = advance_s;

endmodule

// File: rtl/multi_rate_counter.sv
// Up/down counter advanced at a selectable rate, with saturating synchronous
// load and registered tick/wrap pulses.
module multi_rate_counter
    import rate_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int CNT_W     = 4,
    parameter int MAX_COUNT = 2**CNT_W - 1
) (
    input logic                   clk_i,
    input logic                   rst_i,
    multi_rate_counter_if.slave   bus
);

    localparam int DIV_RAW = $clog2(64'(CLK_HZ) * 64'd4);
    localparam int DIV_W   = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tick_q;
    logic             tick_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             advance_s;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
    ) u_tick_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .run_i     (bus.run),
        .restart_i (bus.load),
        .speed_i   (bus.speed),
        .advance_o (advance_s)
    );

    // Count value and event pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    // Load wins over an advance due on the same edge; loads saturate at MAX_COUNT.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.load) begin
            if (bus.load_value > MAX_C) begin
                count_d = MAX_C;
            end else begin
                count_d = bus.load_value;
            end
        end else if (advance_s) begin
            tick_d = 1'b1;
            if (bus.up) begin
                if (count_q >= MAX_C) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1'b1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_C;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1'b1);
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    assign bus.counter_value = count_q;
    assign bus.tick          = tick_q;
    assign bus.wrap          = wrap_q;

endmodule

// File: doc/multi_rate_counter.md
MULTI_RATE_COUNTER -- requirements
Module: multi_rate_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning count value width.
REQ-003 The block SHALL have parameter MAX_COUNT, default 2**CNT_W-1, meaning the largest count value before wrap.
REQ-004 The block SHALL have derived localparam DIV_W = clog2(4*CLK_HZ), meaning divider register width.
REQ-005 ClockIn  input  1  sole clock; all state changes on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Speed  input  2  rate select: 0 = every cycle, 1 = CLK_HZ cycles, 2 = 2*CLK_HZ cycles, 3 = 4*CLK_HZ cycles.
REQ-008 Run  input  1  high = divider and counter advance; low = both hold (pause).
REQ-009 Up  input  1  count direction: 1 = increment, 0 = decrement.
REQ-010 Load  input  1  synchronous load of LoadValue into counter.
REQ-011 LoadValue  input  CNT_W  value loaded when Load=1.
REQ-012 CounterValue  output  CNT_W  current count, registered.
REQ-013 Tick  output  1  one-cycle pulse on the edge where counter advanced, registered.
REQ-014 Wrap  output  1  one-cycle pulse on the edge where counter wrapped, registered.

Function
REQ-015 The divider SHALL reload with PERIOD(Speed)-1 when it reaches 0 and count down by 1 otherwise, only while Run=1.
REQ-016 An advance event SHALL occur on an edge where Run=1, divider==0 and the registered Speed equals Speed.
REQ-017 On an advance event with Up=1, CounterValue SHALL go to CounterValue+1, or to 0 if it equals MAX_COUNT (Wrap=1).
REQ-018 On an advance event with Up=0, CounterValue SHALL go to CounterValue-1, or to MAX_COUNT if it equals 0 (Wrap=1).
REQ-019 Tick SHALL be 1 for exactly the cycle following each advance event and 0 otherwise; Wrap likewise for wrap events.
REQ-020 Speed 0 SHALL give an advance on every cycle with Run=1 (period 1, divider stays 0).
REQ-021 When Speed differs from its registered copy, the divider SHALL reload PERIOD(new Speed)-1 on that edge, and no advance SHALL occur on that edge.
REQ-022 Load=1 SHALL take priority over any advance on that edge: CounterValue<=min(LoadValue,MAX_COUNT), Tick=0, Wrap=0, divider reloads PERIOD(Speed)-1, regardless of Run.
REQ-023 With Run=0 and Load=0, divider, CounterValue and the registered Speed SHALL hold; Tick and Wrap SHALL be 0.
REQ-024 Up changes SHALL take effect at the next advance without restarting the divider.
REQ-025 All arithmetic SHALL be unsigned, with no overflow beyond DIV_W/CNT_W; MAX_COUNT < 2**CNT_W.

Reset
REQ-026 Reset=1 SHALL immediately force CounterValue=0, Tick=0, Wrap=0, divider=0 and registered Speed=0, regardless of ClockIn.
REQ-027 Reset asserted mid-period SHALL discard the partial period; after release the first edge sees a Speed mismatch (if Speed!=0) and reloads per REQ-021.

Structure
REQ-028 A shared package rate_pkg SHALL hold the speed encoding constants and the PERIOD(speed, clk_hz) function.
REQ-029 The divider (REQ-015, REQ-016, REQ-020, REQ-021) SHALL be a sub-module named tick_gen that outputs an advance strobe; the counter, load and wrap logic SHALL live in multi_rate_counter.

Verification (CLK_HZ=4, CNT_W=4, MAX_COUNT=9)
REQ-030 Reset, Speed=1, Run=1, Up=1 -> first Tick after 5 edges (mismatch reload + 4), then every 4 cycles; CounterValue 0,1,2...
REQ-031 Up=1 counting from 9 -> CounterValue=0 with Wrap=1 and Tick=1 in the same cycle; Up=0 from 0 -> 9 with Wrap=1.
REQ-032 Speed=0, Run=1 -> CounterValue increments every cycle; toggling Run low for 3 cycles -> value holds 3 cycles, Tick=0.
REQ-033 Load=1, LoadValue=12 while an advance is due -> CounterValue=9, Tick=0, next Tick 4 cycles later at Speed=1.
REQ-034 Speed 3->1 mid-period -> no Tick on the change edge, next Tick exactly 4 cycles after it.
REQ-035 Reset pulse between clock edges mid-count -> outputs 0 before the next edge; count restarts from 0.
